// File: rtl/dualmem_pkg.sv
// Shared types and helpers for the dual-port buffer byte packer.
// DUALMEM_PACK_BIGENDIAN_EN selects big-endian lane order in lane_idx().
package dualmem_pkg;

    localparam int DUALMEM_BYTES      = 8;
    localparam int DUALMEM_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DROP,
        S_DONE
    } dm_state_e;

    // Maps the k-th byte of a word onto its byte lane.
    function automatic logic [2:0] lane_idx(input logic [2:0] k);
`ifdef DUALMEM_PACK_BIGENDIAN_EN
        return 3'd7 - k;
`else
        return k;
`endif
    endfunction

endpackage

// File: rtl/dualmem_word_acc.sv
// Byte-to-word accumulator: lane counter, packing register and byte mask.
// The word and mask outputs already include the byte being pushed this cycle.
module dualmem_word_acc
    import dualmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  din,
    output logic        empty,
    output logic        emit,
    output logic [63:0] word,
    output logic [7:0]  mask
);

    logic [2:0]  cnt_q,  cnt_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  lane;

    always_comb begin
        lane  = lane_idx(cnt_q);
        word  = data_q;
        mask  = mask_q;
        if (push) begin
            word[{lane, 3'b000} +: 8] = din;
            mask[lane]                = 1'b1;
        end
        emit  = push && ((cnt_q == 3'd7) || last);
        empty = (cnt_q == 3'd0);

        cnt_d  = cnt_q;
        data_d = data_q;
        mask_d = mask_q;
        // Emitting hands the word off, so the accumulator starts fresh next cycle.
        if (clr || emit) begin
            cnt_d  = 3'd0;
            data_d = '0;
            mask_d = '0;
        end else if (push) begin
            cnt_d  = cnt_q + 3'd1;
            data_d = word;
            mask_d = mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/dualmem_byte_packer.sv
// Packs a framed byte stream into 64-bit words written through one buffer port.
// Build option: DUALMEM_PACK_BIGENDIAN_EN (big-endian lane order, see dualmem_pkg).
module dualmem_byte_packer
    import dualmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DUALMEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_en,
    output logic [7:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_din,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] WORD_CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

    dm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic                  lpend_q, lpend_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            wr_we_q, wr_we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]           wr_din_q, wr_din_d;

    logic        acc_clr, acc_push, acc_empty, acc_emit;
    logic [63:0] acc_word;
    logic [7:0]  acc_mask;
    logic        accept, full;

    dualmem_word_acc u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .push  (acc_push),
        .last  (s_last),
        .din   (s_data),
        .empty (acc_empty),
        .emit  (acc_emit),
        .word  (acc_word),
        .mask  (acc_mask)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        lpend_d  = lpend_q;
        acc_clr  = 1'b0;
        acc_push = 1'b0;
        s_ready  = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        accept   = 1'b0;
        full     = (wcnt_q == WORD_CAP) && acc_empty;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECV;
                    base_d  = base_addr;
                    wcnt_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    lpend_d = 1'b0;
                    acc_clr = 1'b1;
                end
            end
            S_RECV: begin
                // After s_last the final write goes out first; done follows a cycle later.
                if (lpend_q) begin
                    lpend_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    s_ready = 1'b1;
                    accept  = s_valid;
                    if (accept) begin
                        if (full) begin
                            ovf_d   = 1'b1;
                            state_d = s_last ? S_DONE : S_DROP;
                        end else begin
                            acc_push = 1'b1;
                            len_d    = len_q + LEN_WIDTH'(1);
                            lpend_d  = s_last;
                        end
                    end
                end
            end
            S_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_emit) wcnt_d = wcnt_q + 1'b1;

        wr_en_d   = acc_emit;
        wr_we_d   = acc_emit ? acc_mask : 8'h00;
        wr_din_d  = acc_emit ? acc_word : 64'h0;
        wr_addr_d = acc_emit ? base_q + wcnt_q[ADDR_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            wcnt_q    <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            lpend_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_we_q   <= '0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            wcnt_q    <= wcnt_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            lpend_q   <= lpend_d;
            wr_en_q   <= wr_en_d;
            wr_we_q   <= wr_we_d;
            wr_addr_q <= wr_addr_d;
            wr_din_q  <= wr_din_d;
        end
    end

    assign mem_en    = wr_en_q;
    assign mem_we    = wr_we_q;
    assign mem_addr  = wr_addr_q;
    assign mem_din   = wr_din_q;
    assign frame_len = len_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dualmem_byte_packer.sv
// Scoreboard bench for dualmem_byte_packer: stimulus pushes expected writes and
// done events, a negedge monitor pops and compares them as the DUT produces them.
module tb_dualmem_byte_packer;

    localparam int AW = 9;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready, mem_en, busy, done, overflow;
    logic [7:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_din;
    logic [LW-1:0] frame_len;

    dualmem_byte_packer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done), .frame_len(frame_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] we; logic [63:0] din; } wr_t;
    typedef struct packed { logic [LW-1:0] len; logic ovf; logic gap_chk; } dn_t;

    wr_t        wr_q[$];
    dn_t        dn_q[$];
    logic [7:0] bq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int stalls = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tb_lane(input int k);
`ifdef DUALMEM_PACK_BIGENDIAN_EN
        return 7 - k;
`else
        return k;
`endif
    endfunction

    // Expected writes for the first n bytes of bq starting at word address base.
    task automatic exp_words(input int base, input int n);
        for (int w = 0; w * 8 < n; w++) begin
            wr_t e;
            e.din  = '0;
            e.we   = '0;
            e.addr = AW'(base + w);
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < n) begin
                    int l;
                    l = tb_lane(k);
                    e.din[l*8 +: 8] = bq[w*8 + k];
                    e.we[l]         = 1'b1;
                end
            end
            wr_q.push_back(e);
        end
    endtask

    task automatic push_dn(input int len, input logic ovf, input logic gap);
        dn_t d;
        d.len = LW'(len);
        d.ovf = ovf;
        d.gap_chk = gap;
        dn_q.push_back(d);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", {55'd0, mem_addr}, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", {55'd0, mem_addr}, {55'd0, e.addr});
                    chk("wr_we", {56'd0, mem_we}, {56'd0, e.we});
                    chk("wr_din", mem_din, e.din);
                end
                last_wr_cyc = cyc;
            end else if (mem_we != 8'h00) begin
                chk("we_without_en", {56'd0, mem_we}, 64'd0);
            end
            if (done) begin
                done_cnt++;
                chk("done_pulse_width", {63'd0, prev_done}, 64'd0);
                chk("done_with_write", {63'd0, mem_en}, 64'd0);
                if (dn_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("frame_len", {51'd0, frame_len}, {51'd0, d.len});
                    chk("overflow", {63'd0, overflow}, {63'd0, d.ovf});
                    if (d.gap_chk) chk("done_gap", 64'(cyc - last_wr_cyc), 64'd1);
                end
            end
        end
        prev_done = done;
    end

    task automatic do_start(input int b);
        start = 1'b1;
        base_addr = AW'(b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input bit with_last);
        for (int i = 0; i < bq.size(); i++) begin
            int t;
            bit r;
            t = 0;
            s_valid = 1'b1;
            s_data  = bq[i];
            s_last  = with_last && (i == bq.size() - 1);
            forever begin
                @(negedge clk) r = s_ready;
                @(posedge clk); #1;
                if (r) break;
                stalls++;
                t++;
                if (t > 20) begin
                    chk("accept_timeout", 64'd1, 64'd0);
                    s_valid = 1'b0;
                    s_last = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 30 && done_cnt < target; t++) begin
            @(posedge clk); #1;
        end
        chk("done_seen", 64'(done_cnt), 64'(target));
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
        chk({tag, "_mem_en"}, {63'd0, mem_en}, 64'd0);
        chk({tag, "_mem_we"}, {56'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, {55'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_din"}, mem_din, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_frame_len"}, {51'd0, frame_len}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        chk_idle_outputs("reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("post_reset");
        @(posedge clk); #1;

        // Frame 1: base 0, bytes 01..10, hand-computed words.
        bq.delete();
        for (int i = 0; i < 16; i++) bq.push_back(8'(i + 1));
`ifdef DUALMEM_PACK_BIGENDIAN_EN
        wr_q.push_back('{addr: 9'd0, we: 8'hFF, din: 64'h0102030405060708});
        wr_q.push_back('{addr: 9'd1, we: 8'hFF, din: 64'h090A0B0C0D0E0F10});
`else
        wr_q.push_back('{addr: 9'd0, we: 8'hFF, din: 64'h0807060504030201});
        wr_q.push_back('{addr: 9'd1, we: 8'hFF, din: 64'h100F0E0D0C0B0A09});
`endif
        push_dn(16, 1'b0, 1'b1);
        stalls = 0;
        do_start(0);
        send(1'b1);
        chk("f1_stalls", 64'(stalls), 64'd0);
        wait_done(1);

        // Frame 2: base 5, AA BB CC; a second start while busy must be ignored.
        bq.delete();
        bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC);
`ifdef DUALMEM_PACK_BIGENDIAN_EN
        wr_q.push_back('{addr: 9'd5, we: 8'hE0, din: 64'hAABBCC0000000000});
`else
        wr_q.push_back('{addr: 9'd5, we: 8'h07, din: 64'h0000000000CCBBAA});
`endif
        push_dn(3, 1'b0, 1'b1);
        do_start(5);
        chk("f2_busy", {63'd0, busy}, 64'd1);
        do_start(9);
        send(1'b1);
        wait_done(2);

        // Frame 3: base 510, 24 bytes, wraps to address 0.
        bq.delete();
        for (int i = 0; i < 24; i++) bq.push_back(8'(8'h20 + i));
        exp_words(510, 24);
        chk("f3_wrap_addr", {55'd0, wr_q[wr_q.size()-1].addr}, 64'd0);
        push_dn(24, 1'b0, 1'b1);
        do_start(510);
        send(1'b1);
        wait_done(3);

        // Frame 4: 4100 bytes overflow a 4096-byte buffer; tail is dropped.
        bq.delete();
        for (int i = 0; i < 4100; i++) bq.push_back(8'(i));
        exp_words(0, 4096);
        chk("f4_exp_writes", 64'(wr_q.size()), 64'd512);
        push_dn(4096, 1'b1, 1'b0);
        stalls = 0;
        do_start(0);
        send(1'b1);
        chk("f4_stalls", 64'(stalls), 64'd0);
        wait_done(4);
        chk("f4_writes_left", 64'(wr_q.size()), 64'd0);

        // Frame 5: reset after 5 bytes of a word; nothing may be written.
        bq.delete();
        for (int i = 0; i < 5; i++) bq.push_back(8'(8'h50 + i));
        do_start(3);
        send(1'b0);
        #2 rst = 1'b1;
        chk_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        chk_idle_outputs("after_midrst");
        @(posedge clk); #1;
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'(8'h30 + i));
        exp_words(7, 8);
        push_dn(8, 1'b0, 1'b1);
        do_start(7);
        send(1'b1);
        wait_done(5);

        repeat (5) @(posedge clk);
        #1;
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("dn_q_empty", 64'(dn_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
